// File: rtl/hazard_sched_ctrl_if.sv
// ID/EX sequencing bundle between the decoder, EX resolution and the hazard controller.
// Used by hazard_sched_ctrl (optional HAZARD_FORWARD_EN build has the same bundle).
interface hazard_sched_ctrl_if #(
    parameter int REG_ADDR_W = 5,
    parameter int PERF_W     = 16
);
    logic                  id_valid;
    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic                  id_uses_rs1;
    logic                  id_uses_rs2;
    logic [REG_ADDR_W-1:0] id_rd;
    logic                  id_regwrite;
    logic                  id_memread;
    logic                  id_is_ctrl;
    logic                  ex_resolved;
    logic                  ex_taken;
    logic                  stall;
    logic                  issue_nop;
    logic                  flush_if;
    logic                  br_timeout_err;
    logic [PERF_W-1:0]     stall_cnt;

    modport master (
        output id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
        output id_rd, id_regwrite, id_memread, id_is_ctrl,
        output ex_resolved, ex_taken,
        input  stall, issue_nop, flush_if, br_timeout_err, stall_cnt
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
        input  id_rd, id_regwrite, id_memread, id_is_ctrl,
        input  ex_resolved, ex_taken,
        output stall, issue_nop, flush_if, br_timeout_err, stall_cnt
    );
endinterface

// File: rtl/hazard_sched_ctrl.sv
// ID/EX hazard scoreboard and control-flow sequencer for the RV32 pipeline.
// Define HAZARD_FORWARD_EN when the EX/MEM bypass exists (load-use interlock only).
module hazard_sched_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int PIPE_DEPTH = 3,
    parameter int BR_TIMEOUT = 8,
    parameter int PERF_W     = 16
) (
    input  logic               clk,
    input  logic               reset,
    hazard_sched_ctrl_if.slave bus
);
    localparam int TW = $clog2(BR_TIMEOUT + 1);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        BR_WAIT = 2'd1,
        FLUSH   = 2'd2
    } state_t;

    typedef struct packed {
        logic                  v;
        logic [REG_ADDR_W-1:0] rd;
        logic                  ld;
    } sb_t;

    state_t                  state, state_n;
    sb_t [PIPE_DEPTH-1:0]    sb;
    sb_t                     sb_new;
    logic [TW-1:0]           tmo_cnt;
    logic                    tmo_hit;
    logic                    hazard;
    logic                    run_stall;
    logic                    run_br;
    logic                    stall, issue_nop, flush_if;
    logic                    err;
    logic [PERF_W-1:0]       cnt;
    logic                    rs1_live, rs2_live;
    logic                    sb_unused;

    assign rs1_live = bus.id_uses_rs1 && (bus.id_rs1 != '0);
    assign rs2_live = bus.id_uses_rs2 && (bus.id_rs2 != '0);

    // WB slot is tracked for the shift but never compared (write-before-read RF)
    assign sb_unused = ^sb;

    always_comb begin
        hazard = 1'b0;
`ifdef HAZARD_FORWARD_EN
        if (sb[0].v && sb[0].ld &&
            ((rs1_live && bus.id_rs1 == sb[0].rd) ||
             (rs2_live && bus.id_rs2 == sb[0].rd)))
            hazard = 1'b1;
`else
        for (int i = 0; i < PIPE_DEPTH - 1; i++) begin
            if (sb[i].v &&
                ((rs1_live && bus.id_rs1 == sb[i].rd) ||
                 (rs2_live && bus.id_rs2 == sb[i].rd)))
                hazard = 1'b1;
        end
`endif
    end

    assign run_stall = bus.id_valid && hazard;
    assign run_br    = bus.id_valid && bus.id_is_ctrl && !hazard;

    always_comb begin
        state_n   = state;
        stall     = 1'b0;
        issue_nop = 1'b0;
        flush_if  = 1'b0;
        tmo_hit   = 1'b0;
        unique case (state)
            RUN: begin
                stall     = run_stall;
                issue_nop = run_stall;
                state_n   = run_br ? BR_WAIT : RUN;
            end
            BR_WAIT: begin
                // not-taken resolution releases ID in the same cycle
                if (bus.ex_resolved && !bus.ex_taken) begin
                    stall     = run_stall;
                    issue_nop = run_stall;
                    state_n   = run_br ? BR_WAIT : RUN;
                end else begin
                    stall     = 1'b1;
                    issue_nop = 1'b1;
                    if (bus.ex_resolved) begin
                        state_n = FLUSH;
                    end else if (tmo_cnt == TW'(BR_TIMEOUT - 1)) begin
                        state_n = RUN;
                        tmo_hit = 1'b1;
                    end
                end
            end
            FLUSH: begin
                flush_if  = 1'b1;
                issue_nop = 1'b1;
                state_n   = RUN;
            end
            default: state_n = RUN;
        endcase
    end

    always_comb begin
        sb_new.v  = bus.id_valid && !stall && !issue_nop &&
                    bus.id_regwrite && (bus.id_rd != '0);
        sb_new.rd = bus.id_rd;
        sb_new.ld = bus.id_memread;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= RUN;
            sb      <= '0;
            tmo_cnt <= '0;
            err     <= 1'b0;
            cnt     <= '0;
        end else begin
            state <= state_n;
            sb    <= {sb[PIPE_DEPTH-2:0], sb_new};
            if (state == BR_WAIT && state_n == BR_WAIT && !bus.ex_resolved)
                tmo_cnt <= tmo_cnt + 1'b1;
            else
                tmo_cnt <= '0;
            if (tmo_hit)
                err <= 1'b1;
            if (stall && !(&cnt))
                cnt <= cnt + 1'b1;
        end
    end

    assign bus.stall          = stall;
    assign bus.issue_nop      = issue_nop;
    assign bus.flush_if       = flush_if;
    assign bus.br_timeout_err = err;
    assign bus.stall_cnt      = cnt;
endmodule

// File: tb/tb_hazard_sched_ctrl.sv
// Directed bench for hazard_sched_ctrl: RAW/load-use stalls, branch FSM,
// timeout, and mid-operation reset (expectations follow HAZARD_FORWARD_EN).
module tb_hazard_sched_ctrl;
    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;
    int   exp_cnt;

`ifdef HAZARD_FORWARD_EN
    localparam int RAW_ST = 0;
    localparam int LU_ST  = 1;
`else
    localparam int RAW_ST = 2;
    localparam int LU_ST  = 2;
`endif

    hazard_sched_ctrl_if #(.REG_ADDR_W(5), .PERF_W(16)) bus ();

    hazard_sched_ctrl #(
        .REG_ADDR_W(5),
        .PIPE_DEPTH(3),
        .BR_TIMEOUT(8),
        .PERF_W(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs1, rs2,
                          input logic u1, u2, input logic [4:0] rd,
                          input logic rw, mr, ctrl);
        bus.id_valid    = v;
        bus.id_rs1      = rs1;
        bus.id_rs2      = rs2;
        bus.id_uses_rs1 = u1;
        bus.id_uses_rs2 = u2;
        bus.id_rd       = rd;
        bus.id_regwrite = rw;
        bus.id_memread  = mr;
        bus.id_is_ctrl  = ctrl;
    endtask

    task automatic idle(input int n);
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // present an instruction, hold it while stalled, count stall cycles
    task automatic issue(input string tag, input logic [4:0] rs1, rs2,
                         input logic u1, u2, input logic [4:0] rd,
                         input logic rw, mr, ctrl, input int exp_st);
        int st;
        st = 0;
        set_id(1, rs1, rs2, u1, u2, rd, rw, mr, ctrl);
        @(negedge clk);
        while (bus.stall && st < 20) begin
            chk({tag, "_nop"}, bus.issue_nop, 1);
            st++;
            @(negedge clk);
        end
        chk(tag, st, exp_st);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        exp_cnt = 0;
        reset   = 1'b0;
        set_id(1, 5, 5, 1, 1, 7, 1, 1, 1);
        bus.ex_resolved = 1'b1;
        bus.ex_taken    = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", bus.stall, 0);
        chk("rst_nop", bus.issue_nop, 0);
        chk("rst_flush", bus.flush_if, 0);
        chk("rst_err", bus.br_timeout_err, 0);
        chk("rst_cnt", bus.stall_cnt, 0);
        bus.ex_resolved = 1'b0;
        bus.ex_taken    = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        issue("add_x5", 1, 2, 1, 1, 5, 1, 0, 0, 0);
        issue("sub_raw", 5, 3, 1, 1, 6, 1, 0, 0, RAW_ST);
        exp_cnt += RAW_ST;
        chk("cnt_raw", bus.stall_cnt, exp_cnt);
        idle(3);

        issue("lw_x7", 1, 0, 1, 0, 7, 1, 1, 0, 0);
        issue("add_lu", 7, 7, 1, 1, 8, 1, 0, 0, LU_ST);
        exp_cnt += LU_ST;
        chk("cnt_lu", bus.stall_cnt, exp_cnt);
        idle(3);

        issue("lw_x0", 1, 0, 1, 0, 0, 1, 1, 0, 0);
        issue("add_x0", 0, 0, 1, 1, 8, 1, 0, 0, 0);
        idle(3);

        issue("beq_t", 1, 2, 1, 1, 0, 0, 0, 1, 0);
        set_id(1, 1, 1, 1, 1, 9, 1, 0, 0);
        @(negedge clk);
        chk("bt_w1_stall", bus.stall, 1);
        chk("bt_w1_nop", bus.issue_nop, 1);
        @(posedge clk);
        #1;
        bus.ex_resolved = 1'b1;
        bus.ex_taken    = 1'b1;
        @(negedge clk);
        chk("bt_w2_stall", bus.stall, 1);
        chk("bt_w2_flush", bus.flush_if, 0);
        @(posedge clk);
        #1;
        bus.ex_resolved = 1'b0;
        bus.ex_taken    = 1'b0;
        @(negedge clk);
        chk("bt_fl_flush", bus.flush_if, 1);
        chk("bt_fl_nop", bus.issue_nop, 1);
        chk("bt_fl_stall", bus.stall, 0);
        @(posedge clk);
        #1;
        bus.ex_resolved = 1'b1;
        bus.ex_taken    = 1'b1;
        @(negedge clk);
        chk("bt_run_flush", bus.flush_if, 0);
        chk("bt_run_stall", bus.stall, 0);
        @(posedge clk);
        #1;
        bus.ex_resolved = 1'b0;
        bus.ex_taken    = 1'b0;
        @(negedge clk);
        chk("bt_stray_flush", bus.flush_if, 0);
        idle(3);
        exp_cnt += 2;
        chk("cnt_bt", bus.stall_cnt, exp_cnt);

        issue("beq_nt", 1, 2, 1, 1, 0, 0, 0, 1, 0);
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("nt_w1_stall", bus.stall, 1);
        @(posedge clk);
        #1;
        bus.ex_resolved = 1'b1;
        bus.ex_taken    = 1'b0;
        @(negedge clk);
        chk("nt_res_stall", bus.stall, 0);
        chk("nt_res_flush", bus.flush_if, 0);
        @(posedge clk);
        #1;
        bus.ex_resolved = 1'b0;
        @(negedge clk);
        chk("nt_next_flush", bus.flush_if, 0);
        @(posedge clk);
        #1;
        exp_cnt += 1;
        chk("cnt_nt", bus.stall_cnt, exp_cnt);

        issue("beq_tmo", 3, 4, 1, 1, 0, 0, 0, 1, 0);
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("tmo_stall", bus.stall, 1);
            chk("tmo_err_low", bus.br_timeout_err, 0);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk("tmo_run", bus.stall, 0);
        chk("tmo_err_set", bus.br_timeout_err, 1);
        @(posedge clk);
        #1;
        exp_cnt += 8;
        chk("cnt_tmo", bus.stall_cnt, exp_cnt);
        issue("add_after_tmo", 1, 2, 1, 1, 10, 1, 0, 0, 0);
        idle(3);
        chk("err_sticky", bus.br_timeout_err, 1);

        issue("add_x11", 1, 2, 1, 1, 11, 1, 0, 0, 0);
        issue("jal_x12", 0, 0, 0, 0, 12, 1, 0, 1, 0);
        set_id(1, 12, 11, 1, 1, 13, 1, 0, 0);
        #1;
        chk("mr_pre_stall", bus.stall, 1);
        reset = 1'b0;
        #1;
        chk("mr_stall", bus.stall, 0);
        chk("mr_nop", bus.issue_nop, 0);
        chk("mr_flush", bus.flush_if, 0);
        chk("mr_err", bus.br_timeout_err, 0);
        chk("mr_cnt", bus.stall_cnt, 0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        issue("add_x13", 12, 11, 1, 1, 13, 1, 0, 0, 0);
        chk("mr_cnt_after", bus.stall_cnt, 0);
        idle(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
